// File: rtl/imem_loadable.sv
// Loadable instruction memory: hardware clear after reset, streaming valid/ready
// program load, and a registered byte-addressed fetch port with misalign flag.
module imem_loadable #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              MISALIGN,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic [ADDR_W-1:0] LD_COUNT
);

  localparam int unsigned OFF   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic                misalign_q, misalign_d;
  logic                busy_q, busy_d;
  logic                ld_ready_q, ld_ready_d;
  logic                ld_done_q, ld_done_d;
  logic [ADDR_W-1:0]   ld_count_q, ld_count_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   rd_idx;
  logic                rd_fire;

  assign rd_idx  = ADDR >> OFF;
  assign rd_fire = (state_q == S_RUN) && RD_EN;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    q_d        = q_q;
    q_valid_d  = rd_fire;
    misalign_d = rd_fire && (|ADDR[OFF-1:0]);
    ld_done_d  = 1'b0;
    ld_count_d = ld_count_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = LD_DATA;

    // Out-of-range fetches still complete, returning zero.
    if (rd_fire) begin
      q_d = (rd_idx >= DEPTH_A) ? '0 : mem_q[rd_idx[IDX_W-1:0]];
    end else begin
      q_d = q_q;
    end

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        ptr_d     = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_RUN: begin
        if (LD_START) begin
          state_d    = S_LOAD;
          ptr_d      = '0;
          ld_count_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (LD_VALID) begin
          mem_we     = 1'b1;
          ptr_d      = ptr_q + IDX_W'(1);
          ld_count_d = ld_count_q + ADDR_W'(1);
          // The top word ends the load even without LD_LAST.
          if (LD_LAST || (ptr_q == LAST_IDX)) begin
            state_d   = S_RUN;
            ld_done_d = 1'b1;
            ptr_d     = '0;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase

    busy_d     = (state_d != S_RUN);
    ld_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      misalign_q <= misalign_d;
      busy_q     <= busy_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      ld_count_q <= ld_count_d;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign Q        = q_q;
  assign Q_VALID  = q_valid_q;
  assign MISALIGN = misalign_q;
  assign BUSY     = busy_q;
  assign LD_READY = ld_ready_q;
  assign LD_DONE  = ld_done_q;
  assign LD_COUNT = ld_count_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: fetches push expected words, a negedge
// monitor pops and compares whenever Q_VALID is seen.
module tb_imem_loadable;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  ADDR;
  logic        RD_EN;
  logic [15:0] Q;
  logic        Q_VALID;
  logic        MISALIGN;
  logic        BUSY;
  logic        LD_START;
  logic        LD_VALID;
  logic [15:0] LD_DATA;
  logic        LD_LAST;
  logic        LD_READY;
  logic        LD_DONE;
  logic [7:0]  LD_COUNT;

  typedef struct {
    logic [15:0] q;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] ld_vec [0:139];
  int          acc, dones, done_at, cyc;

  imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .RD_EN(RD_EN),
    .Q(Q), .Q_VALID(Q_VALID), .MISALIGN(MISALIGN), .BUSY(BUSY),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_LAST(LD_LAST), .LD_READY(LD_READY), .LD_DONE(LD_DONE),
    .LD_COUNT(LD_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid fetch result must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && Q_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_q_valid", 32'(Q_VALID), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("read_q", 32'(Q), 32'(e.q));
        chk("read_misalign", 32'(MISALIGN), 32'(e.mis));
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, 32'(Q), 32'd0);
    chk({tag, "_q_valid"}, 32'(Q_VALID), 32'd0);
    chk({tag, "_misalign"}, 32'(MISALIGN), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_ld_ready"}, 32'(LD_READY), 32'd0);
    chk({tag, "_ld_done"}, 32'(LD_DONE), 32'd0);
    chk({tag, "_ld_count"}, 32'(LD_COUNT), 32'd0);
  endtask

  task automatic wait_clear();
    cyc = 0;
    while (BUSY === 1'b1 && cyc < 1000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("clear_cycles", 32'(cyc), 32'd128);
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp, input logic mis);
    ADDR  = a;
    RD_EN = 1'b1;
    sb.push_back('{q: exp, mis: mis});
    @(posedge CLK); #1;
    RD_EN = 1'b0;
  endtask

  task automatic do_load(input int n, input bit use_last, input int stalls, input bit rd_in_stall);
    logic rdy;
    LD_START = 1'b1;
    @(posedge CLK); #1;
    LD_START = 1'b0;
    RD_EN    = 1'b0;
    acc = 0; dones = 0; done_at = -1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stalls; s++) begin
          LD_VALID = 1'b0;
          ADDR     = 8'h00;
          RD_EN    = rd_in_stall;
          @(posedge CLK); #1;
          RD_EN = 1'b0;
          if (rd_in_stall) chk("read_while_busy", 32'(Q_VALID), 32'd0);
        end
      end
      LD_VALID = 1'b1;
      LD_DATA  = ld_vec[i];
      LD_LAST  = use_last && (i == n - 1);
      rdy      = LD_READY;
      @(posedge CLK); #1;
      if (rdy) acc++;
      if (LD_DONE) begin
        dones++;
        done_at = i;
      end
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    @(posedge CLK); #1;
    if (LD_DONE) dones++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; ADDR = 8'h00; RD_EN = 1'b0; LD_START = 1'b0;
    LD_VALID = 1'b0; LD_DATA = 16'h0000; LD_LAST = 1'b0;
    #12;
    chk_reset("por");
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    wait_clear();
    rd(8'h00, 16'h0000, 1'b0);
    rd(8'hFE, 16'h0000, 1'b0);

    // Basic three-word load.
    ld_vec[0] = 16'hF001; ld_vec[1] = 16'h517F; ld_vec[2] = 16'h2A79;
    do_load(3, 1'b1, 0, 1'b0);
    chk("load1_accepted", 32'(acc), 32'd3);
    chk("load1_done_pulses", 32'(dones), 32'd1);
    chk("load1_count", 32'(LD_COUNT), 32'd3);
    chk("load1_busy", 32'(BUSY), 32'd0);
    rd(8'h00, 16'hF001, 1'b0);
    rd(8'h02, 16'h517F, 1'b0);
    rd(8'h04, 16'h2A79, 1'b0);
    rd(8'h06, 16'h0000, 1'b0);

    // Same words with two stall cycles between each, fetching while busy.
    do_load(3, 1'b1, 2, 1'b1);
    chk("stall_accepted", 32'(acc), 32'd3);
    chk("stall_done_pulses", 32'(dones), 32'd1);
    chk("stall_count", 32'(LD_COUNT), 32'd3);
    rd(8'h00, 16'hF001, 1'b0);
    rd(8'h02, 16'h517F, 1'b0);
    rd(8'h04, 16'h2A79, 1'b0);
    rd(8'h06, 16'h0000, 1'b0);

    rd(8'h03, 16'h517F, 1'b1);

    // One-word reload; a fetch in the LD_START cycle is still served.
    ld_vec[0] = 16'h1234;
    ADDR  = 8'h04;
    RD_EN = 1'b1;
    sb.push_back('{q: 16'h2A79, mis: 1'b0});
    do_load(1, 1'b1, 0, 1'b0);
    chk("reload_count", 32'(LD_COUNT), 32'd1);
    chk("reload_done_pulses", 32'(dones), 32'd1);
    rd(8'h00, 16'h1234, 1'b0);
    rd(8'h02, 16'h517F, 1'b0);
    rd(8'h01, 16'h1234, 1'b1);

    // Full-depth stream without LD_LAST.
    for (int i = 0; i < 140; i++) ld_vec[i] = 16'hA000 + 16'(i);
    do_load(130, 1'b0, 0, 1'b0);
    chk("full_accepted", 32'(acc), 32'd128);
    chk("full_done_pulses", 32'(dones), 32'd1);
    chk("full_done_at", 32'(done_at), 32'd127);
    chk("full_count", 32'(LD_COUNT), 32'd128);
    chk("full_ready_after", 32'(LD_READY), 32'd0);
    rd(8'h00, 16'hA000, 1'b0);
    rd(8'hFE, 16'hA07F, 1'b0);
    rd(8'h51, 16'hA028, 1'b1);

    // Reset in the middle of a load.
    do_load(5, 1'b0, 0, 1'b0);
    chk("partial_accepted", 32'(acc), 32'd5);
    chk("partial_done_pulses", 32'(dones), 32'd0);
    chk("partial_count", 32'(LD_COUNT), 32'd5);
    RESET_N = 1'b0;
    #1;
    chk_reset("midload");
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    wait_clear();
    rd(8'h00, 16'h0000, 1'b0);
    rd(8'h08, 16'h0000, 1'b0);
    rd(8'hFE, 16'h0000, 1'b0);

    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the lab CPU with byte-addressed fetch.
- Compared with the fixed reset-initialised program ROM, it adds three things:
  - a hardware clear sequence after reset;
  - a streaming program-load port with a valid/ready handshake;
  - a registered (1-cycle) read with a valid flag and a misalignment flag.
- Sits between the PC/fetch stage and an external loader (test bench, UART loader).

Parameters:
- DATA_W, 16, instruction word width in bits; must be 16 or 32.
- ADDR_W, 8, byte-address width of ADDR.
- DEPTH, 128, number of words; must be ≤ 2**(ADDR_W - log2(DATA_W/8)).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ADDR  in  ADDR_W  fetch byte address.
- RD_EN  in  1  fetch request.
- Q  out  DATA_W  fetched instruction word.
- Q_VALID  out  1  Q holds data for the request of the previous cycle.
- MISALIGN  out  1  previous request had non-zero low byte-offset bits.
- BUSY  out  1  high in CLEAR and LOAD states; fetches are ignored.
- LD_START  in  1  begin a program load at word 0.
- LD_VALID  in  1  LD_DATA is valid.
- LD_DATA  in  DATA_W  program word.
- LD_LAST  in  1  marks the final word of the load.
- LD_READY  out  1  memory accepts a word this cycle.
- LD_DONE  out  1  one-cycle pulse when a load completes.
- LD_COUNT  out  ADDR_W  number of words written by the last load.

Behaviour:
- Word index:
  - OFF = log2(DATA_W/8).
  - Word index = ADDR >> OFF.
  - If the index is ≥ DEPTH, a read returns 0, still with Q_VALID=1.
- Reset (RESET_N low, asynchronous):
  - state=CLEAR, ptr=0.
  - Q=0, Q_VALID=0, MISALIGN=0, BUSY=1, LD_READY=0, LD_DONE=0, LD_COUNT=0.
- CLEAR state:
  - Writes 0 to mem[ptr] and increments ptr each cycle.
  - After mem[DEPTH-1] is written (DEPTH cycles after reset release), goes to RUN with BUSY=0.
- RUN state:
  - If RD_EN=1, on the next edge: Q=mem[index], Q_VALID=1, MISALIGN=|ADDR[OFF-1:0]|.
  - A misaligned read still returns the word containing the byte.
  - If RD_EN=0, on the next edge: Q holds its previous value, Q_VALID=0, MISALIGN=0.
- Entering LOAD:
  - LD_START=1 in RUN causes the next state to be LOAD, with ptr=0, BUSY=1, LD_READY=1, LD_COUNT=0.
  - A fetch presented in the same cycle as LD_START is still served.
  - LD_START in CLEAR or LOAD is ignored.
- LOAD state:
  - LD_READY=1.
  - Each cycle with LD_VALID=1, mem[ptr]=LD_DATA, ptr and LD_COUNT increment.
  - LD_VALID=0 is a stall: no write, ptr unchanged.
  - Words above the last loaded address keep their prior contents.
- Load termination:
  - The load ends on the accepted word with LD_LAST=1, or on the accepted write to word DEPTH-1 (auto-terminate even without LD_LAST).
  - Next cycle: state=RUN, LD_READY=0, BUSY=0, LD_DONE=1 for exactly one cycle.
  - LD_COUNT holds the final count until the next LD_START or reset.
- While BUSY:
  - RD_EN is ignored; Q_VALID=0 and Q holds.
- Reset asserted mid-LOAD or mid-CLEAR:
  - Immediate return to reset values.
  - A full CLEAR follows, so partially loaded contents are lost.
- Only one write port. Reads are never serviced in CLEAR or LOAD, so read/write collisions are impossible.

Test Plan:
- Reset then idle:
  - Pulse RESET_N low, release, hold RD_EN=0 → BUSY=1 for exactly 128 cycles, then 0.
  - RD_EN at ADDR=0x00 and 0xFE → Q=0x0000, Q_VALID=1 one cycle after each request.
- Load and fetch:
  - LD_START, stream 0xF001, 0x517F, 0x2A79 with LD_LAST on the third word → LD_DONE pulses once, LD_COUNT=3.
  - Reads at ADDR=0x00, 0x02, 0x04 → 0xF001, 0x517F, 0x2A79; ADDR=0x06 → 0x0000.
- Stalled load:
  - Insert 2 LD_VALID=0 cycles between words → no extra writes, LD_COUNT=3, same contents as above.
  - RD_EN during LOAD → Q_VALID stays 0.
- Misalign and reload:
  - RD_EN at ADDR=0x03 → Q=mem[1], MISALIGN=1.
  - Reload of 1 word 0x1234 → mem[0]=0x1234, mem[1]=0x517F retained.
- Full-depth auto-terminate:
  - Stream 130 words with no LD_LAST → 128 accepted, LD_DONE after word 127, LD_COUNT=128.
  - Word 128 is not accepted (LD_READY=0).
- Reset mid-load:
  - Assert RESET_N after 5 accepted words → outputs go to reset values immediately.
  - After CLEAR, ADDR=0x00 reads 0x0000.
